// File: rtl/pipe_skid_stage.sv
// Elastic pipeline register with a 2-entry skid buffer, flush and stall counter.
// Back-pressure is registered: IN_READY depends only on the skid register.
module pipe_skid_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             FLUSH,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic             FULL,
  output logic [CNT_W-1:0] STALL_COUNT
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } state_t;

  state_t           r_state;
  logic             r_m_valid;
  logic             r_s_valid;
  logic [WIDTH-1:0] r_m_data;
  logic [WIDTH-1:0] r_s_data;
  logic [CNT_W-1:0] r_cnt;

  logic w_in_fire;
  logic w_out_fire;
  logic w_stall;

  assign w_in_fire  = IN_VALID & ~r_s_valid;
  assign w_out_fire = r_m_valid & OUT_READY;
  assign w_stall    = r_m_valid & ~OUT_READY;

  assign IN_READY    = ~r_s_valid;
  assign OUT_VALID   = r_m_valid;
  assign OUT_DATA    = r_m_data;
  assign FULL        = r_s_valid;
  assign STALL_COUNT = r_cnt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= EMPTY;
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
      r_m_data  <= '0;
      r_s_data  <= '0;
      r_cnt     <= '0;
    end else begin
      if (w_stall && !(&r_cnt))
        r_cnt <= r_cnt + CNT_W'(1);

      if (FLUSH) begin
        r_state   <= EMPTY;
        r_m_valid <= 1'b0;
        r_s_valid <= 1'b0;
        r_m_data  <= '0;
        r_s_data  <= '0;
      end else begin
        unique case (r_state)
          EMPTY: begin
            if (w_in_fire) begin
              r_state   <= ONE;
              r_m_valid <= 1'b1;
              r_m_data  <= IN_DATA;
            end
          end
          ONE: begin
            unique case (1'b1)
              w_in_fire & w_out_fire: begin
                r_m_data <= IN_DATA;
              end
              w_in_fire & ~w_out_fire: begin
                r_state   <= TWO;
                r_s_valid <= 1'b1;
                r_s_data  <= IN_DATA;
              end
              ~w_in_fire & w_out_fire: begin
                r_state   <= EMPTY;
                r_m_valid <= 1'b0;
              end
              default: ;
            endcase
          end
          TWO: begin
            // Skid drains into main; input is blocked this cycle
            if (w_out_fire) begin
              r_state   <= ONE;
              r_s_valid <= 1'b0;
              r_m_data  <= r_s_data;
              r_s_data  <= '0;
            end
          end
          default: begin
            r_state   <= EMPTY;
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed table, corner sequences and a
// randomised run against a queue-based reference model.
module tb_pipe_skid_stage;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        FLUSH;
  logic        IN_VALID;
  logic [31:0] IN_DATA;
  logic        OUT_READY;

  logic        in_ready,  in_ready3;
  logic        out_valid, out_valid3;
  logic [31:0] out_data,  out_data3;
  logic        full,      full3;
  logic [15:0] cnt16;
  logic [2:0]  cnt3;

  int n_total = 0;
  int n_pass  = 0;

  always #5 CLK = ~CLK;

  pipe_skid_stage #(.WIDTH(32), .CNT_W(16)) dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_READY(in_ready), .IN_DATA(IN_DATA),
    .OUT_VALID(out_valid), .OUT_READY(OUT_READY), .OUT_DATA(out_data),
    .FULL(full), .STALL_COUNT(cnt16)
  );

  pipe_skid_stage #(.WIDTH(32), .CNT_W(3)) dut3 (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_READY(in_ready3), .IN_DATA(IN_DATA),
    .OUT_VALID(out_valid3), .OUT_READY(OUT_READY), .OUT_DATA(out_data3),
    .FULL(full3), .STALL_COUNT(cnt3)
  );

  typedef struct {
    logic        rst;
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        ov;
    logic [31:0] od;
    logic        full;
    logic        ir;
    int          cnt;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(logic rst, logic iv, logic [31:0] id,
                              logic ordy, logic ov, logic [31:0] od,
                              logic f, logic ir, int cnt);
    vec_t v;
    v.rst = rst; v.iv = iv; v.id = id; v.ordy = ordy;
    v.ov = ov; v.od = od; v.full = f; v.ir = ir; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(string name, longint act, longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(logic rst, logic fl, logic iv,
                       logic [31:0] id, logic ordy);
    RESET = rst; FLUSH = fl; IN_VALID = iv;
    IN_DATA = id; OUT_READY = ordy;
  endtask

  // reference model state
  logic [31:0] q[$];
  logic [31:0] hold;
  int          m16, m3;

  initial begin
    drive(1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1);

    vecs[0]  = mk(1, 1, 32'hDEADBEEF, 1, 0, 32'h0, 0, 1, 0);
    vecs[1]  = mk(1, 1, 32'hDEADBEEF, 1, 0, 32'h0, 0, 1, 0);
    vecs[2]  = mk(0, 1, 32'h1, 1, 1, 32'h1, 0, 1, 0);
    vecs[3]  = mk(0, 1, 32'h2, 1, 1, 32'h2, 0, 1, 0);
    vecs[4]  = mk(0, 1, 32'h3, 1, 1, 32'h3, 0, 1, 0);
    vecs[5]  = mk(0, 0, 32'h0, 1, 0, 32'h3, 0, 1, 0);
    vecs[6]  = mk(0, 1, 32'hA, 0, 1, 32'hA, 0, 1, 0);
    vecs[7]  = mk(0, 1, 32'hB, 0, 1, 32'hA, 1, 0, 1);
    vecs[8]  = mk(0, 1, 32'hC, 0, 1, 32'hA, 1, 0, 2);
    vecs[9]  = mk(0, 1, 32'hC, 1, 1, 32'hB, 0, 1, 2);
    vecs[10] = mk(0, 1, 32'hC, 1, 1, 32'hC, 0, 1, 2);
    vecs[11] = mk(0, 0, 32'h0, 1, 0, 32'hC, 0, 1, 2);

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].rst, 1'b0, vecs[i].iv, vecs[i].id, vecs[i].ordy);
      tick();
      chk($sformatf("vec%0d.ov", i), out_valid, vecs[i].ov);
      chk($sformatf("vec%0d.od", i), out_data, vecs[i].od);
      chk($sformatf("vec%0d.full", i), full, vecs[i].full);
      chk($sformatf("vec%0d.ir", i), in_ready, vecs[i].ir);
      chk($sformatf("vec%0d.cnt", i), cnt16, vecs[i].cnt);
    end

    // flush in state TWO with a competing input
    drive(0, 0, 1, 32'h10, 0); tick();
    drive(0, 0, 1, 32'h11, 0); tick();
    chk("flush.pre_full", full, 1);
    chk("flush.pre_od", out_data, 32'h10);
    drive(0, 1, 1, 32'h12, 0); tick();
    chk("flush.ov", out_valid, 0);
    chk("flush.full", full, 0);
    chk("flush.ir", in_ready, 1);
    chk("flush.od", out_data, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 32'h0, 1); tick();
      chk("flush.no12_ov", out_valid, 0);
      chk("flush.no12_od", out_data, 0);
    end

    // counter saturation on the CNT_W=3 instance
    drive(1, 0, 0, 0, 0); tick();
    chk("sat.reset", cnt3, 0);
    drive(0, 0, 1, 32'h20, 0); tick();
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0, 0); tick();
    end
    chk("sat.cnt3", cnt3, 7);
    chk("sat.cnt16", cnt16, 10);
    chk("sat.od", out_data3, 32'h20);
    tick();
    chk("sat.hold", cnt3, 7);
    drive(0, 1, 0, 0, 0); tick();
    chk("sat.flush3", cnt3, 7);
    chk("sat.flush16", cnt16, 12);
    chk("sat.flush_ov", out_valid3, 0);
    drive(0, 0, 0, 0, 0); tick();
    chk("sat.idle", cnt3, 7);
    drive(1, 0, 0, 0, 0); tick();
    chk("sat.rst3", cnt3, 0);
    chk("sat.rst16", cnt16, 0);

    // randomised run against the queue model
    q.delete(); hold = 0; m16 = 0; m3 = 0;
    for (int c = 0; c < 10000; c++) begin
      logic rst, fl, iv, ordy, ovm, irm;
      logic [31:0] id;
      rst  = ($urandom % 1000) == 0;
      fl   = ($urandom % 60) == 0;
      iv   = ($urandom % 4) != 0;
      ordy = (c % 2000 < 1000) ? (($urandom % 3) != 0)
                               : (($urandom % 3) == 0);
      id   = $urandom;
      drive(rst, fl, iv, id, ordy);
      ovm = q.size() > 0;
      irm = q.size() < 2;
      tick();
      if (rst) begin
        q.delete(); hold = 0; m16 = 0; m3 = 0;
      end else begin
        if (ovm && !ordy) begin
          if (m16 < 65535) m16++;
          if (m3 < 7) m3++;
        end
        if (fl) begin
          q.delete(); hold = 0;
        end else begin
          if (ovm && ordy) hold = q.pop_front();
          if (iv && irm) q.push_back(id);
        end
      end
      chk("rnd.ov", out_valid, q.size() > 0);
      chk("rnd.od", out_data, q.size() > 0 ? q[0] : hold);
      chk("rnd.full", full, q.size() == 2);
      chk("rnd.ir", in_ready, q.size() < 2);
      chk("rnd.cnt16", cnt16, m16);
      chk("rnd.cnt3", cnt3, m3);
      chk("rnd.legal", (!out_valid && full), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised elastic pipeline register for inter-stage boundaries (IF/ID … MEM/WB) in the RISC-V pipeline. It replaces the global-stall pipeline register with a valid/ready handshake and a 2-entry skid buffer, so back-pressure is registered rather than combinational. It also adds a synchronous flush for branch/hazard squashing and a saturating stall-cycle counter for performance monitoring. Payload is an opaque WIDTH-bit bundle (control bits, ALU result, read data, rd address, PC) packed by the instantiating stage.

## Interface
Parameters:
- WIDTH, 32, payload width in bits (≥1)
- CNT_W, 16, stall counter width in bits (≥1)

Ports:
- CLK  input  1  clock; all state updates on posedge
- RESET  input  1  synchronous, active-high; clock CLK
- FLUSH  input  1  synchronous squash of all held entries
- IN_VALID  input  1  upstream has payload
- IN_READY  output  1  stage can accept; equals !FULL
- IN_DATA  input  WIDTH  upstream payload
- OUT_VALID  output  1  OUT_DATA is valid
- OUT_READY  input  1  downstream accepts
- OUT_DATA  output  WIDTH  head payload, driven directly from main register
- FULL  output  1  skid register occupied
- STALL_COUNT  output  CNT_W  saturating count of back-pressured cycles

## Operation
- Storage: main register M (m_valid, m_data) drives OUT_*; skid register S (s_valid, s_data); FULL = s_valid; IN_READY = !s_valid; OUT_VALID = m_valid.
- in_fire = IN_VALID & IN_READY; out_fire = OUT_VALID & OUT_READY.
- States: EMPTY (!m_valid, !s_valid), ONE (m_valid, !s_valid), TWO (m_valid, s_valid). The state !m_valid & s_valid is illegal and must never occur.
- EMPTY: in_fire → ONE, M ← IN_DATA; else stay.
- ONE: in_fire & out_fire → ONE, M ← IN_DATA. in_fire & !out_fire → TWO, S ← IN_DATA. !in_fire & out_fire → EMPTY. Neither → hold.
- TWO: IN_READY = 0. out_fire → ONE, M ← s_data, s_data ← 0. Else hold.
- FIFO order is preserved; no payload is duplicated or dropped except by FLUSH or RESET.
- FLUSH (RESET takes priority): next state EMPTY, m_data = s_data = 0. An out_fire in the flush cycle counts as delivered downstream. An in_fire in the flush cycle is discarded.
- RESET: m_valid = s_valid = 0, m_data = s_data = 0, STALL_COUNT = 0. Handshakes in the reset cycle are ignored.
- STALL_COUNT increments by 1 in each cycle with OUT_VALID & !OUT_READY and saturates at 2^CNT_W−1. It is cleared only by RESET; FLUSH does not affect it.
- Payload registers load only on the transitions above; an unloaded payload register keeps its value.

## Timing
- Reset values: OUT_VALID 0, OUT_DATA 0, FULL 0, IN_READY 1, STALL_COUNT 0.
- Latency: IN_DATA accepted at edge k appears on OUT_DATA/OUT_VALID after edge k (usable in cycle k+1). No combinational in→out path.
- Throughput: 1 transfer/cycle sustained while OUT_READY = 1.
- IN_READY depends on registered state only; it has no combinational path from OUT_READY.
- Back-pressure: after OUT_READY drops, at most one further input is accepted (into S). IN_READY falls on the next edge.
- IN_READY rises on the edge following the out_fire that drains S.
- Upstream may change IN_DATA while IN_VALID & !IN_READY; the stage must not sample it.
- FLUSH effects (OUT_VALID = 0, IN_READY = 1) are visible the cycle after FLUSH is sampled high.

## Test plan
- Reset: hold RESET 2 cycles with IN_VALID = 1, IN_DATA = 0xDEADBEEF → OUT_VALID 0, OUT_DATA 0, IN_READY 1, STALL_COUNT 0.
- Streaming: OUT_READY = 1, push 0x1, 0x2, 0x3 on consecutive cycles → OUT_DATA 0x1, 0x2, 0x3 on the three following cycles; FULL stays 0.
- Skid: push 0xA, then 0xB with OUT_READY = 0 → FULL = 1, IN_READY = 0, OUT_DATA holds 0xA. Offered 0xC is not taken. Raise OUT_READY → outputs 0xA, 0xB, 0xC in order.
- Flush: in state TWO holding 0x10/0x11, assert FLUSH with IN_VALID = 1, IN_DATA = 0x12 → next cycle OUT_VALID 0, FULL 0; 0x12 never appears on OUT_DATA.
- Counter saturation with CNT_W = 3: OUT_VALID = 1, OUT_READY = 0 for 10 cycles → STALL_COUNT reads 7 and holds at 7. FLUSH leaves it at 7; RESET clears it to 0.
- Random: randomised IN_VALID/OUT_READY over 10k cycles against a scoreboard → in-order delivery, no loss or duplication, illegal state never reached.
